// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port framebuffer BRAM between display read-out
// (absolute priority during active video) and two round-robin pixel writers.
`default_nettype none

module fb_port_arbiter #(
   parameter int H_ACTIVE     = 1280,
   parameter int V_ACTIVE     = 720,
   parameter int ADDR_WIDTH   = 20,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic                  pixel_clk_in,
   input  logic                  rst_n_in,
   input  logic                  ad_in,
   input  logic                  nf_in,
   input  logic                  wr0_valid_in,
   input  logic [ADDR_WIDTH-1:0] wr0_addr_in,
   input  logic [DATA_WIDTH-1:0] wr0_data_in,
   output logic                  wr0_ready_out,
   input  logic                  wr1_valid_in,
   input  logic [ADDR_WIDTH-1:0] wr1_addr_in,
   input  logic [DATA_WIDTH-1:0] wr1_data_in,
   output logic                  wr1_ready_out,
   output logic                  mem_en_out,
   output logic                  mem_we_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [DATA_WIDTH-1:0] mem_din_out,
   input  logic [DATA_WIDTH-1:0] mem_dout_in,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  pixel_valid_out,
   output logic [15:0]           wr_stall_count_out,
   output logic                  addr_err_out
);

   localparam int                    FB_SIZE   = H_ACTIVE * V_ACTIVE;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);
   localparam int                    VLD_LEN   = READ_LATENCY + 2;

   typedef enum logic [0:0] {
      WAIT_SYNC = 1'b0,
      RUN       = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   disp_addr_q, disp_addr_d;
   logic                    last1_q, last1_d;
   logic [15:0]             stall_cnt_q, stall_cnt_d;
   logic [15:0]             stall_out_q, stall_out_d;
   logic                    addr_err_q, addr_err_d;
   logic                    mem_en_q, mem_en_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
   logic [VLD_LEN-1:0]      vld_q, vld_d;
   logic [DATA_WIDTH-1:0]   pixel_q, pixel_d;

   logic                    disp_rd;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic                    sel1;
   logic                    rdy0, rdy1;
   logic                    xfer0, xfer1;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic                    wr_in_range;
   logic                    wr_issue;
   logic                    stall;

   // Arbitration: port 1 wins only when port 0 is idle or port 0 was served last.
   always_comb begin
      disp_rd     = (state_q == RUN) && ad_in;
      rd_addr     = nf_in ? '0 : disp_addr_q;
      sel1        = wr1_valid_in && (!wr0_valid_in || !last1_q);
      rdy0        = rst_n_in && !disp_rd && !sel1;
      rdy1        = rst_n_in && !disp_rd && sel1;
      xfer0       = rdy0 && wr0_valid_in;
      xfer1       = rdy1 && wr1_valid_in;
      wr_addr     = xfer1 ? wr1_addr_in : wr0_addr_in;
      wr_data     = xfer1 ? wr1_data_in : wr0_data_in;
      wr_in_range = (wr_addr <= LAST_ADDR);
      wr_issue    = (xfer0 || xfer1) && wr_in_range;
      stall       = (wr0_valid_in && !rdy0) || (wr1_valid_in && !rdy1);
   end

   always_comb begin
      state_d     = state_q;
      disp_addr_d = disp_addr_q;
      last1_d     = last1_q;
      stall_cnt_d = stall_cnt_q;
      stall_out_d = stall_out_q;
      addr_err_d  = addr_err_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      vld_d       = {vld_q[VLD_LEN-2:0], disp_rd};
      pixel_d     = vld_q[READ_LATENCY] ? mem_dout_in : pixel_q;

      if (state_q == WAIT_SYNC && nf_in) begin
         state_d = RUN;
      end

      if (disp_rd) begin
         disp_addr_d = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_WIDTH'(1);
      end else if (nf_in) begin
         disp_addr_d = '0;
      end

      if (xfer1) begin
         last1_d = 1'b1;
      end else if (xfer0) begin
         last1_d = 1'b0;
      end

      if (nf_in) begin
         stall_out_d = stall_cnt_q;
         stall_cnt_d = '0;
      end else if (stall && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end

      if ((xfer0 || xfer1) && !wr_in_range) begin
         addr_err_d = 1'b1;
      end

      if (disp_rd) begin
         mem_en_d   = 1'b1;
         mem_addr_d = rd_addr;
      end else if (wr_issue) begin
         mem_en_d   = 1'b1;
         mem_we_d   = 1'b1;
         mem_addr_d = wr_addr;
         mem_din_d  = wr_data;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= WAIT_SYNC;
         disp_addr_q <= '0;
         last1_q     <= 1'b1;
         stall_cnt_q <= '0;
         stall_out_q <= '0;
         addr_err_q  <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         vld_q       <= '0;
         pixel_q     <= '0;
      end else begin
         state_q     <= state_d;
         disp_addr_q <= disp_addr_d;
         last1_q     <= last1_d;
         stall_cnt_q <= stall_cnt_d;
         stall_out_q <= stall_out_d;
         addr_err_q  <= addr_err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         vld_q       <= vld_d;
         pixel_q     <= pixel_d;
      end
   end

   assign wr0_ready_out      = rdy0;
   assign wr1_ready_out      = rdy1;
   assign mem_en_out         = mem_en_q;
   assign mem_we_out         = mem_we_q;
   assign mem_addr_out       = mem_addr_q;
   assign mem_din_out        = mem_din_q;
   assign pixel_out          = pixel_q;
   assign pixel_valid_out    = vld_q[VLD_LEN-1];
   assign wr_stall_count_out = stall_out_q;
   assign addr_err_out       = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: randomized scoreboard bench for fb_port_arbiter on a small 16x4 frame.
`default_nettype none

module tb_fb_port_arbiter;

   localparam int H  = 16;
   localparam int V  = 4;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int RL = 2;
   localparam int FB = H * V;

   logic          clk = 1'b0;
   logic          rst_n_in;
   logic          ad_in, nf_in;
   logic          wr0_valid_in, wr1_valid_in;
   logic [AW-1:0] wr0_addr_in, wr1_addr_in;
   logic [DW-1:0] wr0_data_in, wr1_data_in;
   logic          wr0_ready_out, wr1_ready_out;
   logic          mem_en_out, mem_we_out;
   logic [AW-1:0] mem_addr_out;
   logic [DW-1:0] mem_din_out;
   logic [DW-1:0] mem_dout_in;
   logic [DW-1:0] pixel_out;
   logic          pixel_valid_out;
   logic [15:0]   wr_stall_count_out;
   logic          addr_err_out;

   always #5 clk = ~clk;

   fb_port_arbiter #(
      .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
   ) dut (
      .pixel_clk_in(clk), .rst_n_in(rst_n_in), .ad_in(ad_in), .nf_in(nf_in),
      .wr0_valid_in(wr0_valid_in), .wr0_addr_in(wr0_addr_in), .wr0_data_in(wr0_data_in),
      .wr0_ready_out(wr0_ready_out),
      .wr1_valid_in(wr1_valid_in), .wr1_addr_in(wr1_addr_in), .wr1_data_in(wr1_data_in),
      .wr1_ready_out(wr1_ready_out),
      .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
      .mem_din_out(mem_din_out), .mem_dout_in(mem_dout_in),
      .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out),
      .wr_stall_count_out(wr_stall_count_out), .addr_err_out(addr_err_out)
   );

   // Preloaded framebuffer contents: a fixed function of the address.
   function automatic logic [DW-1:0] pix(input int a);
      return DW'(a * 40503 + 17) ^ 16'h5A5A;
   endfunction

   // Two-stage BRAM read pipeline; non-read cycles return a poison value.
   logic [DW-1:0] rd_stage;
   always @(posedge clk) begin
      rd_stage    <= (mem_en_out && !mem_we_out) ? pix(int'(mem_addr_out)) : 16'hDEAD;
      mem_dout_in <= rd_stage;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            due;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } pix_t;

   acc_t exp_acc[$];
   pix_t exp_pix[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state
   bit synced;
   int ptr;
   bit last1;
   int stall_cnt;
   int stall_out;
   bit err;

   task automatic model_reset();
      synced = 0; ptr = 0; last1 = 1; stall_cnt = 0; stall_out = 0; err = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a memory access or a pixel.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n_in) begin
            while (exp_acc.size() > 0 && exp_acc[0].due < cyc) begin
               checks++; failures++;
               $display("FAIL mem_missing: no access seen, expected we=%0d addr=%0d at cycle %0d",
                        exp_acc[0].we, exp_acc[0].addr, exp_acc[0].due);
               void'(exp_acc.pop_front());
            end
            if (mem_en_out) begin
               checks++;
               if (exp_acc.size() == 0 || exp_acc[0].due != cyc) begin
                  failures++;
                  $display("FAIL mem_unexpected: got we=%0d addr=%0d, required no access (cycle %0d)",
                           mem_we_out, mem_addr_out, cyc);
               end else begin
                  acc_t e;
                  e = exp_acc.pop_front();
                  if (mem_we_out !== e.we || mem_addr_out !== e.addr ||
                      (e.we && mem_din_out !== e.data)) begin
                     failures++;
                     $display("FAIL mem_access: got we=%0d addr=%0d din=%0h required we=%0d addr=%0d din=%0h",
                              mem_we_out, mem_addr_out, mem_din_out, e.we, e.addr, e.data);
                  end
               end
            end
            while (exp_pix.size() > 0 && exp_pix[0].due < cyc) begin
               checks++; failures++;
               $display("FAIL pixel_missing: no pixel seen, expected %0h at cycle %0d",
                        exp_pix[0].data, exp_pix[0].due);
               void'(exp_pix.pop_front());
            end
            if (pixel_valid_out) begin
               checks++;
               if (exp_pix.size() == 0 || exp_pix[0].due != cyc) begin
                  failures++;
                  $display("FAIL pixel_unexpected: got %0h, required no pixel (cycle %0d)", pixel_out, cyc);
               end else begin
                  pix_t p;
                  p = exp_pix.pop_front();
                  if (pixel_out !== p.data) begin
                     failures++;
                     $display("FAIL pixel_data: got %0h required %0h", pixel_out, p.data);
                  end
               end
            end
         end
      end
   end

   // One clock of stimulus; the model predicts readies and queues the resulting traffic.
   task automatic step(input bit ad, input bit nf, input bit v0, input int a0,
                       input bit v1, input int a1);
      logic [DW-1:0] d0, d1;
      bit rd, r0, r1, t0, t1;
      int raddr, wa;
      logic [DW-1:0] wd;
      d0 = DW'($urandom);
      d1 = DW'($urandom);
      @(posedge clk);
      #1;
      ad_in = ad; nf_in = nf;
      wr0_valid_in = v0; wr0_addr_in = AW'(a0); wr0_data_in = d0;
      wr1_valid_in = v1; wr1_addr_in = AW'(a1); wr1_data_in = d1;
      @(negedge clk);
      chk("stall_count", 64'(wr_stall_count_out), 64'(stall_out));
      chk("addr_err", 64'(addr_err_out), 64'(err));

      rd = synced && ad;
      raddr = nf ? 0 : ptr;
      r0 = 0; r1 = 0;
      if (!rd) begin
         if (v0 && v1) begin r0 = last1; r1 = !last1; end
         else if (v1)  r1 = 1;
         else          r0 = 1;
      end
      chk("ready", {62'b0, wr1_ready_out, wr0_ready_out}, {62'b0, r1, r0});
      t0 = r0 && v0;
      t1 = r1 && v1;

      if (rd) begin
         exp_acc.push_back('{cyc + 1, 1'b0, AW'(raddr), '0});
         exp_pix.push_back('{cyc + RL + 2, pix(raddr)});
      end
      if (t0 || t1) begin
         wa = t1 ? a1 : a0;
         wd = t1 ? d1 : d0;
         if (wa < FB) exp_acc.push_back('{cyc + 1, 1'b1, AW'(wa), wd});
         else         err = 1;
         last1 = t1;
      end
      if (nf) begin
         stall_out = stall_cnt;
         stall_cnt = 0;
      end else if ((v0 && !r0) || (v1 && !r1)) begin
         if (stall_cnt < 65535) stall_cnt++;
      end
      if (rd)      ptr = (raddr + 1) % FB;
      else if (nf) ptr = 0;
      if (nf) synced = 1;
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {wr0_ready_out, wr1_ready_out, mem_en_out, mem_we_out, pixel_valid_out,
                 addr_err_out, mem_addr_out, mem_din_out, pixel_out, wr_stall_count_out}, 64'd0);
   endtask

   task automatic idle_inputs();
      ad_in = 0; nf_in = 0;
      wr0_valid_in = 0; wr0_addr_in = '0; wr0_data_in = '0;
      wr1_valid_in = 0; wr1_addr_in = '0; wr1_data_in = '0;
   endtask

   initial begin
      rst_n_in = 0;
      idle_inputs();
      model_reset();
      repeat (3) @(negedge clk);
      chk_all_zero("reset_state");
      rst_n_in = 1;

      // Unsynchronised: both writers contend, ad_in must be ignored.
      for (int i = 0; i < 12; i++)
         step(1'($urandom), 0, 1, $urandom_range(0, FB - 1), 1, $urandom_range(0, FB - 1));

      // Sync, then one active line with writer 0 stalled throughout.
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < H; i++) step(1, 0, 1, $urandom_range(0, FB - 1), 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, $urandom_range(0, FB - 1), 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("stall_after_line", 64'(wr_stall_count_out), 64'(H));

      // nf coincident with ad, then more than a full frame with no nf so the address wraps.
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < FB + 20; i++)
         step(1, 0, 1'($urandom), $urandom_range(0, FB - 1), 1'($urandom), $urandom_range(0, FB - 1));

      // Out-of-range write on port 1.
      step(0, 0, 0, 0, 1, FB);
      step(0, 0, 0, 0, 0, 0);
      chk("addr_err_set", 64'(addr_err_out), 64'd1);

      // Randomized video timing with random writer traffic.
      for (int ln = 0; ln < 150; ln++) begin
         int blank;
         bit nf_line;
         nf_line = ($urandom_range(0, 7) == 0);
         blank = $urandom_range(0, 6);
         for (int i = 0; i < H; i++)
            step(1, nf_line && i == 0, 1'($urandom), $urandom_range(0, FB + FB / 8),
                 1'($urandom), $urandom_range(0, FB + FB / 8));
         for (int i = 0; i < blank; i++)
            step(0, ($urandom_range(0, 15) == 0), 1'($urandom), $urandom_range(0, FB + FB / 8),
                 1'($urandom), $urandom_range(0, FB + FB / 8));
      end

      // Mid-line asynchronous reset.
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 1, 3, 0, 0);
      @(posedge clk);
      #3;
      rst_n_in = 0;
      #1;
      chk_all_zero("midline_reset");
      exp_acc.delete();
      exp_pix.delete();
      model_reset();
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n_in = 1;

      // Back in WAIT_SYNC: ad_in must not trigger reads.
      for (int i = 0; i < 10; i++)
         step(1, 0, 1'($urandom), $urandom_range(0, FB - 1), 1'($urandom), $urandom_range(0, FB - 1));
      for (int i = 0; i < RL + 4; i++) step(0, 0, 0, 0, 0, 0);
      chk("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
      chk("pix_queue_empty", 64'(exp_pix.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates the single-port framebuffer BRAM between display read-out and two pixel writers (camera capture on port 0, overlay/graphics on port 1). Sits between the video signal generator and the framebuffer. Uses the generator's active-display and new-frame strobes to give display reads absolute priority during active video, and grants writers round-robin during blanking. Delivers a pixel stream with fixed latency for the HDMI output path.

## Interface
- H_ACTIVE, 1280: active pixels per line
- V_ACTIVE, 720: active lines per frame
- ADDR_WIDTH, 20: framebuffer address width; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*V_ACTIVE
- DATA_WIDTH, 16: pixel width (RGB565)
- READ_LATENCY, 2: BRAM read latency in cycles (mem_en_out to mem_dout_in valid)

- pixel_clk_in  input  1  pixel clock; all logic on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- ad_in  input  1  active-display strobe from the video signal generator
- nf_in  input  1  single-cycle new-frame strobe from the video signal generator
- wr0_valid_in / wr1_valid_in  input  1  writer request
- wr0_addr_in / wr1_addr_in  input  ADDR_WIDTH  write address
- wr0_data_in / wr1_data_in  input  DATA_WIDTH  write data
- wr0_ready_out / wr1_ready_out  output  1  writer grant; transfer occurs when valid && ready
- mem_en_out  output  1  BRAM port enable (registered)
- mem_we_out  output  1  BRAM write enable (registered)
- mem_addr_out  output  ADDR_WIDTH  BRAM address (registered)
- mem_din_out  output  DATA_WIDTH  BRAM write data (registered)
- mem_dout_in  input  DATA_WIDTH  BRAM read data
- pixel_out  output  DATA_WIDTH  display pixel (registered)
- pixel_valid_out  output  1  pixel_out valid
- wr_stall_count_out  output  16  cycles in the last frame with a valid writer that was not granted
- addr_err_out  output  1  sticky: a writer presented an out-of-range address

## Operation
- States: WAIT_SYNC (reset state) and RUN. WAIT_SYNC → RUN on the first nf_in. RUN is left only by reset.
- WAIT_SYNC: ad_in is ignored and no display reads are issued. Writers are arbitrated every cycle.
- RUN, ad_in=1: a display read is issued at disp_addr. Both writer readies are 0. disp_addr increments, wrapping from H_ACTIVE*V_ACTIVE-1 to 0.
- RUN, ad_in=0: writers are arbitrated.
- nf_in resets disp_addr to 0. If nf_in and ad_in coincide, the read uses address 0 and disp_addr becomes 1.
- Arbitration:
  - Only one writer valid: that writer is granted.
  - Both valid: the writer not served last is granted.
  - Neither valid: port 0 is offered ready.
  - The last-served pointer updates only on a transfer. Its reset value is "port 1", so port 0 wins the first tie.
  - At most one ready is high per cycle. ready may depend combinationally on valid_in and ad_in.
- Write issue:
  - An accepted write with addr < H_ACTIVE*V_ACTIVE drives mem_en=1, we=1, addr and data on the next cycle.
  - An out-of-range write is still accepted (ready=1). It issues no memory access and sets addr_err_out.
- Stall counter: an internal counter increments each cycle in which (wr0_valid && !wr0_ready) || (wr1_valid && !wr1_ready). It saturates at 0xFFFF. On nf_in, the counter value is copied to wr_stall_count_out and the counter is cleared.

## Timing
- Reset: every output is 0, state is WAIT_SYNC, disp_addr is 0, and the stall counter is 0.
- Reset is asynchronous. Asserting it mid-operation drops in-flight reads, so pixel_valid_out goes to 0 immediately.
- Display path: ad_in high at cycle t gives the following.
  - mem_en_out=1, mem_we_out=0 and the address at t+1.
  - Read data at t+1+READ_LATENCY.
  - pixel_out / pixel_valid_out at t+2+READ_LATENCY, i.e. 4 cycles with default parameters.
  - Downstream delays hs/vs/ad by the same amount.
- The valid pipeline is a READ_LATENCY+2 shift register with one entry per read. Write slots carry valid=0.
- When no access is issued, mem_en_out and mem_we_out are 0. mem_addr_out and mem_din_out hold their last value.
- A write transfer at cycle t appears at the memory port at t+1. Writer throughput is 1 per blanking cycle.
- The active-to-blanking boundary is cycle-exact: the first cycle with ad_in=0 may grant a writer. No bubble is required.

## Test plan
- Reset, then hold both writers valid with no nf_in → grants alternate 0,1,0,1 from the first cycle. mem_we_out follows 1 cycle later. pixel_valid_out stays 0.
- nf_in, then 1280 cycles of ad_in → mem_addr_out steps 0..1279 from cycle +1. pixel_valid_out is high for exactly 1280 cycles starting 4 cycles after the first ad_in. pixel_out matches the preloaded BRAM contents.
- Writer 0 valid continuously across an active line → wr0_ready_out is 0 for all 1280 ad_in cycles and 1 on the first blanking cycle. wr_stall_count_out reads 1280 after the next nf_in.
- Full frame with no nf_in on frame 2 → disp_addr wraps from 921599 to 0.
- nf_in concurrent with ad_in → mem_addr_out=0 at the next cycle, then 1.
- Writer 1 write at address 921600 → accepted, no mem_we_out, addr_err_out=1 until reset. Assert rst_n_in mid-line → all outputs 0 within the same cycle, and the state returns to WAIT_SYNC.
